data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder on the controller's load/store interface. It is the memory side of the `MemRead`/`MemWrite`/`busy` handshake that the controller drives as initiator. It accepts one word access at a time and stalls the initiator through `busy` for a configurable latency. It then commits the write, or returns the read word, in a single completion cycle.

## Interface
Parameters:
- `NBITS`, 8, data and address width in bits.
- `DEPTH`, 32, number of words; power of two, at least 2.
- `LATENCY`, 2, cycles `busy` stays high per access; at least 1.

Ports:
- `clock`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `MemRead`  in  1  read request.
- `MemWrite`  in  1  write request; wins over `MemRead` when both are high.
- `addr`  in  NBITS  word address, held stable by the initiator while `busy`=1.
- `wdata`  in  NBITS  write data, held stable while `busy`=1.
- `rdata`  out  NBITS  registered read data.
- `busy`  out  1  access in progress; the initiator must hold its request.
- `done`  out  1  one-cycle completion strobe.
- `err`  out  1  address-range error, valid only when `done`=1.

## Operation
- The state machine has three states: IDLE, WAIT and DONE.
- **IDLE**
  - On `MemRead|MemWrite`, latch the op (write if `MemWrite`), `addr` and `wdata`.
  - Load `cnt` with LATENCY-1 and go to WAIT. If LATENCY=1, go directly to DONE.
  - With no request, stay in IDLE.
- **WAIT**
  - Decrement `cnt` each cycle. When `cnt`=0, go to DONE.
  - Input changes during WAIT are ignored; the latched copies are used.
- **Transition into DONE, at that clock edge**
  - Write: `mem[idx] <= wdata_latched`.
  - Read: `rdata <= mem[idx]`.
  - `idx` = latched `addr[$clog2(DEPTH)-1:0]`. Without range checking, the upper address bits are ignored.
- **DONE**
  - `done`=1 and `busy`=0.
  - The request still present in this cycle is the one just completed and is ignored.
  - Always go to IDLE on the next edge.
- **`busy`** is combinational:
  - 1 when in IDLE with `MemRead|MemWrite` high;
  - 1 in WAIT;
  - 0 otherwise.
- **`rdata`** holds its last read value across writes and idle cycles. It changes only on a read completion or on reset.
- **Write-then-read to the same address:** the read returns the newly written value.

## Timing
- Reset values:
  - state IDLE, `cnt`=0, `rdata`=0, `busy`=0 (request inputs are masked while `reset`=1), `done`=0, `err`=0.
  - All DEPTH memory words are cleared to 0.
- Access latency:
  - Request seen in cycle T: `busy`=1 during T..T+LATENCY-1.
  - `done`=1 with valid `rdata` in cycle T+LATENCY.
  - Idle again at T+LATENCY+1.
- Minimum request spacing is LATENCY+1 cycles. A new request is accepted only in IDLE.
- Reset mid-operation, in WAIT or DONE:
  - Return to IDLE on the next edge and drop the pending write.
  - `rdata` and memory are cleared by reset.
- Both requests high: treated as a write; `rdata` is unchanged.

## Configuration
- `DMEM_ADDR_CHECK_EN` defined:
  - An access with any of `addr[NBITS-1:$clog2(DEPTH)]` nonzero raises `err`=1 in DONE.
  - Such a write is suppressed.
  - Such a read loads `rdata` with 0.
- `DMEM_ADDR_CHECK_EN` undefined:
  - `err` is tied to 0.
  - Upper address bits are ignored, so the address wraps modulo DEPTH.

## Test plan
- Reset, then sample outputs → `rdata`=0, `busy`=0, `done`=0; a read of any address at default parameters returns 0.
- Write 8'hA5 to addr 3 with LATENCY=2 → `busy`=1 for 2 cycles, `done` on cycle 3. A subsequent read of addr 3 returns `rdata`=8'hA5 in its DONE cycle.
- `MemRead` and `MemWrite` both high, addr 5, `wdata`=8'h3C → treated as a write; `rdata` is unchanged; a later read of addr 5 returns 8'h3C.
- Request held high continuously for 10 cycles → exactly one completion per LATENCY+1 cycles, and no double commit in the DONE cycle.
- Write to addr 7, then assert `reset` during WAIT → IDLE next cycle, `busy`=0; a later read of addr 7 returns 0.
- addr=8'h23 (DEPTH=32):
  - with `DMEM_ADDR_CHECK_EN`: `err`=1 in DONE, no write, read gives 0;
  - without it: the access goes to word 3 and `err`=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory side of the MemRead/MemWrite/busy load-store handshake. One word
//   access is accepted at a time. The initiator is stalled through busy for
//   LATENCY cycles. The write is then committed, or the read word returned,
//   in a single completion cycle flagged by done.
//
// Parameters
//   NBITS   data and address width in bits
//   DEPTH   number of words (power of two, >= 2)
//   LATENCY cycles busy stays high per access (>= 1)
//
// Ports
//   clock     rising-edge clock
//   reset     synchronous, active-high reset
//   MemRead   read request
//   MemWrite  write request (wins over MemRead)
//   addr      word address, held while busy
//   wdata     write data, held while busy
//   rdata     registered read data, changes only on read completion or reset
//   busy      access in progress
//   done      one-cycle completion strobe
//   err       address-range error, valid with done
//
// Configuration
//   DMEM_ADDR_CHECK_EN  when defined, an address with nonzero bits above the
//                       word index raises err, suppresses the write and reads
//                       as 0. When undefined, err is 0 and addresses wrap.
module data_mem_responder #(
  parameter int NBITS   = 8,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:0] addr,
  input  logic [NBITS-1:0] wdata,
  output logic [NBITS-1:0] rdata,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic             wr_q;
  logic [NBITS-1:0] addr_q;
  logic [NBITS-1:0] wdata_q;
  logic [NBITS-1:0] mem [DEPTH];

  logic             req;
  logic             accept;
  logic             commit;
  logic             c_wr;
  logic [NBITS-1:0] c_addr;
  logic [NBITS-1:0] c_wdata;
  logic [AW-1:0]    c_idx;
  logic             bad;

  // Requests are masked while reset is high so busy reads 0 in reset.
  assign req    = (MemRead | MemWrite) & ~reset;
  assign accept = (state == S_IDLE) && req;
  assign c_idx  = c_addr[AW-1:0];

  // Next state, handshake outputs and the operands of the commit that happens
  // on the edge into DONE. With LATENCY=1 that edge is the accepting one, so
  // the live inputs are used instead of the not-yet-latched copies.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    commit     = 1'b0;
    c_wr       = wr_q;
    c_addr     = addr_q;
    c_wdata    = wdata_q;

    case (state)
      S_IDLE: begin
        if (req) begin
          busy = 1'b1;
          if (LATENCY == 1) begin
            state_next = S_DONE;
            commit     = 1'b1;
            c_wr       = MemWrite;
            c_addr     = addr;
            c_wdata    = wdata;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        // cnt reaches 0 on this edge, which ends the LATENCY-1 wait cycles.
        if (cnt == CW'(1)) begin
          state_next = S_DONE;
          commit     = 1'b1;
        end
      end
      S_DONE: begin
        // The request still held here belongs to the access just completed.
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef DMEM_ADDR_CHECK_EN
  logic err_q;

  assign bad = (c_addr >> AW) != '0;
  assign err = done & err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= bad;
    end
  end
`else
  logic unused_addr_hi;

  assign bad            = 1'b0;
  assign err            = 1'b0;
  assign unused_addr_hi = ^c_addr;
`endif

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the block order does not matter.
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      // NOTE: clearing every word on reset keeps the array in flip-flops; a
      // RAM macro cannot be reset this way.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= state_next;

      if (accept) begin
        wr_q    <= MemWrite;
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= CW'(LATENCY - 1);
      end else if (state == S_WAIT) begin
        cnt <= cnt - CW'(1);
      end

      if (commit) begin
        if (c_wr) begin
          if (!bad) begin
            mem[c_idx] <= c_wdata;
          end
        end else begin
          rdata <= bad ? '0 : mem[c_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder at default parameters.
// A transaction-level model tracks when each accepted access must complete
// (accept cycle + LATENCY) and what memory and rdata must hold; it is checked
// against the DUT on every non-reset cycle. Directed sequences add literal
// expectations, then a randomized phase exercises mixed traffic.
module tb_data_mem_responder;

  localparam int NBITS   = 8;
  localparam int DEPTH   = 32;
  localparam int LATENCY = 2;

  logic             clock;
  logic             reset;
  logic             MemRead;
  logic             MemWrite;
  logic [NBITS-1:0] addr;
  logic [NBITS-1:0] wdata;
  logic [NBITS-1:0] rdata;
  logic             busy;
  logic             done;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(
    .NBITS  (NBITS),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_bad(input logic [NBITS-1:0] a);
`ifdef DMEM_ADDR_CHECK_EN
    return int'(a) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural model: each cycle, decide from the accept time of the pending
  // access whether the DUT must be stalling or completing, and apply the
  // access to the model memory in its completion cycle.
  initial begin : model
    int               cyc;
    bit               pend;
    int               t0;
    bit               m_wr;
    logic [NBITS-1:0] m_a;
    logic [NBITS-1:0] m_d;
    logic [NBITS-1:0] mem_m [DEPTH];
    logic [NBITS-1:0] rd_m;
    bit               bad;
    int               idx;
    cyc  = 0;
    pend = 0;
    rd_m = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pend = 0;
        rd_m = '0;
        foreach (mem_m[i]) mem_m[i] = '0;
      end else begin
        if (!pend) begin
          check("busy_idle", 32'(busy), 32'(MemRead | MemWrite));
          check("done_idle", 32'(done), 32'd0);
          if (MemRead | MemWrite) begin
            pend = 1;
            t0   = cyc;
            m_wr = MemWrite;
            m_a  = addr;
            m_d  = wdata;
          end
        end else if (cyc - t0 < LATENCY) begin
          check("busy_wait", 32'(busy), 32'd1);
          check("done_wait", 32'(done), 32'd0);
        end else begin
          bad = addr_bad(m_a);
          idx = int'(m_a) % DEPTH;
          if (m_wr) begin
            if (!bad) mem_m[idx] = m_d;
          end else begin
            rd_m = bad ? '0 : mem_m[idx];
          end
          check("done_cpl", 32'(done), 32'd1);
          check("busy_cpl", 32'(busy), 32'd0);
          check("err_cpl", 32'(err), 32'(bad));
          pend = 0;
        end
        check("rdata", 32'(rdata), 32'(rd_m));
      end
      cyc++;
    end
  end

  // One access: request held for LATENCY+1 cycles, address/data scrambled
  // during the wait cycles (the DUT must use its latched copies). Returns
  // the outputs sampled in the completion cycle.
  task automatic access(input logic rd, input logic wr, input logic [NBITS-1:0] a,
                        input logic [NBITS-1:0] d, output logic [NBITS-1:0] r,
                        output logic e, output logic dn);
    @(posedge clock);
    #1;
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = d;
    for (int j = 1; j <= LATENCY; j++) begin
      @(posedge clock);
      if (j < LATENCY) begin
        #1;
        addr  = NBITS'($urandom);
        wdata = NBITS'($urandom);
      end
    end
    @(negedge clock);
    r  = rdata;
    e  = err;
    dn = done;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      addr     = NBITS'($urandom);
      wdata    = NBITS'($urandom);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [NBITS-1:0] r;
    logic             e;
    logic             dn;
    int               n_done;

    reset    = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    addr     = '0;
    wdata    = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_rdata", 32'(rdata), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    access(1'b1, 1'b0, 8'd9, 8'h00, r, e, dn);
    check("read_after_reset", 32'(r), 32'h00);

    access(1'b0, 1'b1, 8'd3, 8'hA5, r, e, dn);
    check("write3_done", 32'(dn), 32'd1);
    access(1'b1, 1'b0, 8'd3, 8'h00, r, e, dn);
    check("read3", 32'(r), 32'hA5);

    access(1'b1, 1'b1, 8'd5, 8'h3C, r, e, dn);
    check("both_rdata_kept", 32'(r), 32'hA5);
    access(1'b1, 1'b0, 8'd5, 8'h00, r, e, dn);
    check("read5", 32'(r), 32'h3C);

    // Request held continuously: one completion every LATENCY+1 cycles.
    @(posedge clock);
    #1;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    addr     = 8'd3;
    n_done   = 0;
    repeat (4 * (LATENCY + 1)) begin
      @(negedge clock);
      if (done) n_done++;
    end
    check("held_completions", 32'(n_done), 32'd4);
    idle(1);

    // Reset during WAIT drops the pending write.
    @(posedge clock);
    #1;
    MemWrite = 1'b1;
    addr     = 8'd7;
    wdata    = 8'h5A;
    @(posedge clock);
    #1;
    reset    = 1'b1;
    MemWrite = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    access(1'b1, 1'b0, 8'd7, 8'h00, r, e, dn);
    check("read7_after_reset", 32'(r), 32'h00);
    access(1'b1, 1'b0, 8'd3, 8'h00, r, e, dn);
    check("read3_after_reset", 32'(r), 32'h00);

    // Out-of-range address 8'h23 against DEPTH=32.
    access(1'b0, 1'b1, 8'h23, 8'h77, r, e, dn);
`ifdef DMEM_ADDR_CHECK_EN
    check("oor_write_err", 32'(e), 32'd1);
`else
    check("oor_write_err", 32'(e), 32'd0);
`endif
    access(1'b1, 1'b0, 8'd3, 8'h00, r, e, dn);
`ifdef DMEM_ADDR_CHECK_EN
    check("oor_alias3", 32'(r), 32'h00);
`else
    check("oor_alias3", 32'(r), 32'h77);
`endif
    access(1'b1, 1'b0, 8'h23, 8'h00, r, e, dn);
`ifdef DMEM_ADDR_CHECK_EN
    check("oor_read", 32'(r), 32'h00);
    check("oor_read_err", 32'(e), 32'd1);
`else
    check("oor_read", 32'(r), 32'h77);
    check("oor_read_err", 32'(e), 32'd0);
`endif
    idle(2);

    // Randomized mixed traffic, checked by the model.
    for (int i = 0; i < 200; i++) begin
      int               k;
      logic [NBITS-1:0] a;
      k = $urandom_range(0, 3);
      a = ($urandom_range(0, 9) == 0) ? NBITS'($urandom) : NBITS'($urandom_range(0, 7));
      access((k == 0 || k == 2 || k == 3) ? 1'b1 : 1'b0, (k == 1 || k == 2) ? 1'b1 : 1'b0,
             a, NBITS'($urandom), r, e, dn);
      idle($urandom_range(0, 2));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
